// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of a 5-stage MIPS pipeline.
//
// Takes the execute-stage result bundle, performs an optional word load or
// store over a req/ack data-memory handshake, resolves conditional branches,
// and registers a writeback bundle for the next stage.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   ex_valid / ex_ready   upstream handshake; transfer on ex_valid & ex_ready
//   ex_alu_result         ALU result, also the memory byte address
//   ex_zero               ALU zero flag (branch condition)
//   ex_new_pc             PC+4 from execute (not consumed by this stage)
//   ex_branch_target      branch target address
//   ex_store_data         store data (rt)
//   ex_mem_read/_write    memory op select (write wins if both)
//   ex_branch, ex_reg_write, ex_mem_to_reg, ex_rd   control / destination
//   dmem_req/we/addr/wdata  memory request, held stable until dmem_ack
//   dmem_ack, dmem_rdata  memory completion; rdata valid with ack
//   wb_valid/reg_write/rd/data  writeback bundle, wb_valid is a pulse
//   pc_src, pc_target     one-cycle branch redirect
//   err                   one-cycle pulse on misaligned access or timeout
module mem_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_new_pc,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              err
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              pc_src_q, pc_src_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic              err_q, err_d;

  // Fields of the in-flight memory op needed to build its writeback.
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;

  logic is_mem;
  logic misaligned;
  logic take_branch;

  // PC+4 has no consumer in this stage; kept on the port for pipeline symmetry.
  logic unused_new_pc;
  assign unused_new_pc = ^ex_new_pc;

  assign is_mem      = ex_mem_read | ex_mem_write;
  assign misaligned  = |ex_alu_result[1:0];
  assign take_branch = ex_branch & ex_zero;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    pc_src_d       = 1'b0;
    pc_target_d    = pc_target_q;
    err_d          = 1'b0;
    alu_d          = alu_q;
    rd_d           = rd_q;
    rw_d           = rw_q;
    m2r_d          = m2r_q;

    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          alu_d = ex_alu_result;
          rd_d  = ex_rd;
          rw_d  = ex_reg_write;
          m2r_d = ex_mem_to_reg;

          // Branch resolution does not depend on the memory op.
          pc_src_d = take_branch;
          if (take_branch) begin
            pc_target_d = ex_branch_target;
          end

          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = ex_alu_result;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = ex_reg_write;
          end else if (misaligned) begin
            // Dropped without touching memory; writeback suppressed.
            err_d          = 1'b1;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_alu_result;
          end else begin
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = ex_alu_result;
            wdata_d = ex_store_data;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        // Ack takes priority over a timeout in the same cycle.
        if (dmem_ack) begin
          req_d          = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = rw_q & ~we_q;
          wb_data_d      = m2r_q ? dmem_rdata : alu_q;
          cnt_d          = '0;
          state_d        = StIdle;
        end else if (cnt_q == CntLast) begin
          req_d          = 1'b0;
          err_d          = 1'b1;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_rd_d        = rd_q;
          wb_data_d      = alu_q;
          cnt_d          = '0;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      pc_src_q       <= 1'b0;
      pc_target_q    <= '0;
      err_q          <= 1'b0;
      alu_q          <= '0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
      m2r_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      pc_src_q       <= pc_src_d;
      pc_target_q    <= pc_target_d;
      err_q          <= err_d;
      alu_q          <= alu_d;
      rd_q           <= rd_d;
      rw_q           <= rw_d;
      m2r_q          <= m2r_d;
    end
  end

  assign ex_ready     = (state_q == StIdle);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign pc_src       = pc_src_q;
  assign pc_target    = pc_target_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback and
// branch-redirect events; a negedge monitor pops and compares them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic        ex_zero = 1'b0;
  logic [31:0] ex_new_pc = '0;
  logic [31:0] ex_branch_target = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_branch = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        err;

  mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_alu_result    (ex_alu_result),
    .ex_zero          (ex_zero),
    .ex_new_pc        (ex_new_pc),
    .ex_branch_target (ex_branch_target),
    .ex_store_data    (ex_store_data),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_branch        (ex_branch),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_rd            (ex_rd),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .wb_valid         (wb_valid),
    .wb_reg_write     (wb_reg_write),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .pc_src           (pc_src),
    .pc_target        (pc_target),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        chk;  // compare rd/data too
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] pc_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                         input logic e, input logic chk);
    wb_exp_t x;
    x.rw = rw; x.rd = rd; x.data = data; x.err = e; x.chk = chk;
    wb_q.push_back(x);
  endtask

  // Presents one op for a single cycle; returns #1 after the transfer edge.
  task automatic send(input logic [31:0] alu, input logic [31:0] sdata, input logic [31:0] tgt,
                      input logic zero, input logic [4:0] rd, input logic mr, input logic mw,
                      input logic br, input logic rw, input logic m2r);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sdata; ex_branch_target = tgt;
    ex_zero = zero; ex_rd = rd; ex_mem_read = mr; ex_mem_write = mw; ex_branch = br;
    ex_reg_write = rw; ex_mem_to_reg = m2r; ex_new_pc = alu + 32'd4;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_branch = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: compare every writeback pulse and every redirect pulse.
  always @(negedge clk) begin
    if (wb_valid) begin
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_valid rd=%0d data=0x%08h expected none at %0t",
                 wb_rd, wb_data, $time);
      end else begin
        wb_exp_t x;
        x = wb_q.pop_front();
        if (wb_reg_write !== x.rw || err !== x.err ||
            (x.chk && (wb_rd !== x.rd || wb_data !== x.data))) begin
          errors++;
          $display("FAIL wb_bundle: got rw=%0b err=%0b rd=%0d data=0x%08h expected rw=%0b err=%0b rd=%0d data=0x%08h at %0t",
                   wb_reg_write, err, wb_rd, wb_data, x.rw, x.err, x.rd, x.data, $time);
        end
      end
    end
    if (err && !wb_valid) begin
      checks++;
      errors++;
      $display("FAIL err_without_wb: got err=1 wb_valid=0 expected wb_valid=1 at %0t", $time);
    end
    if (pc_src) begin
      checks++;
      if (pc_q.size() == 0) begin
        errors++;
        $display("FAIL pc_unexpected: got pc_src=1 target=0x%08h expected pc_src=0 at %0t",
                 pc_target, $time);
      end else begin
        logic [31:0] t;
        t = pc_q.pop_front();
        if (pc_target !== t) begin
          errors++;
          $display("FAIL pc_target: got 0x%08h expected 0x%08h at %0t", pc_target, t, $time);
        end
      end
    end
  end

  initial begin
    int n;
    // Reset values.
    #3;
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_pc_target", pc_target, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // ALU op, then two back-to-back ALU ops.
    push_wb(1'b1, 5'd8, 32'h10, 1'b0, 1'b1);
    send(32'h10, 32'h0, 32'h0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("alu_ex_ready", 32'(ex_ready), 32'd1);
    push_wb(1'b1, 5'd3, 32'hA5A5_0001, 1'b0, 1'b1);
    push_wb(1'b0, 5'd4, 32'h0000_FFFF, 1'b0, 1'b1);
    send(32'hA5A5_0001, 32'h0, 32'h0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'h0000_FFFF, 32'h0, 32'h0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Load, ack on the third request cycle.
    push_wb(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1);
    send(32'h100, 32'h0, 32'h0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("ld_req", 32'(dmem_req), 32'd1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we", 32'(dmem_we), 32'd0);
      check("ld_ex_ready", 32'(ex_ready), 32'd0);
      if (i == 2) begin
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      end
      step();
      dmem_ack = 1'b0;
    end
    check("ld_req_drop", 32'(dmem_req), 32'd0);
    check("ld_ready_back", 32'(ex_ready), 32'd1);
    step();

    // Store with immediate ack.
    push_wb(1'b0, 5'd7, 32'h204, 1'b0, 1'b1);
    send(32'h204, 32'h1234_5678, 32'h0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("st_we", 32'(dmem_we), 32'd1);
    check("st_wdata", dmem_wdata, 32'h1234_5678);
    check("st_addr", dmem_addr, 32'h204);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    step();

    // Read and write both set: store wins.
    push_wb(1'b0, 5'd2, 32'h208, 1'b0, 1'b1);
    send(32'h208, 32'hCAFE_0000, 32'h0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rw_we", 32'(dmem_we), 32'd1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    step();

    // Branch taken, then not taken.
    push_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    pc_q.push_back(32'h40);
    send(32'h0, 32'h0, 32'h40, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_pc_src", 32'(pc_src), 32'd1);
    push_wb(1'b0, 5'd0, 32'h1, 1'b0, 1'b1);
    send(32'h1, 32'h0, 32'h40, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_nt_pc_src", 32'(pc_src), 32'd0);
    step();

    // Misaligned load.
    push_wb(1'b0, 5'd5, 32'h102, 1'b1, 1'b0);
    send(32'h102, 32'h0, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_err", 32'(err), 32'd1);
    step();

    // Timeout: request must stay up exactly 16 cycles.
    push_wb(1'b0, 5'd6, 32'h200, 1'b1, 1'b0);
    send(32'h200, 32'h0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (dmem_req && n < 40) begin
      n++;
      step();
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_err", 32'(err), 32'd1);
    check("to_ready", 32'(ex_ready), 32'd1);
    step();

    // Reset mid-load, then a late ack that must be ignored.
    send(32'h300, 32'h0, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check("rm_req", 32'(dmem_req), 32'd0);
    check("rm_wb_valid", 32'(wb_valid), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    step();
    rst_n = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("rm_ready", 32'(ex_ready), 32'd1);
    check("rm_req_after", 32'(dmem_req), 32'd0);
    step();

    // Recovery after reset.
    push_wb(1'b1, 5'd31, 32'h7777_0000, 1'b0, 1'b1);
    send(32'h7777_0000, 32'h0, 32'h0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    check("pc_queue_drained", 32'(pc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
